eth_frame_builder: RTL and testbench

- Upstream neighbour of the RMII transmit stage.
- Accepts the encoder's byte stream with a valid/ready handshake and cuts it into payload chunks of at most MAX_PAYLOAD bytes.
- Emits each chunk as a byte-paced Ethernet frame: preamble, SFD, dst MAC, src MAC, EtherType, payload, zero pad to 46 bytes, then a silent gap.
- The transmit stage downstream appends the FCS and serialises to dibits.

---
 rtl/eth_pkg.sv | 20 ++
 rtl/eth_frame_builder_sync_fifo.sv | 53 +++++
 rtl/eth_frame_builder.sv | 223 ++++++++++++++++++++++
 tb/tb_eth_frame_builder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet frame builder.
package eth_pkg;

  typedef enum logic [3:0] {
    IDLE, PREAMBLE, SFD, DST, SRC, TYPE, SEQ, PAYLOAD, PAD, IFG
  } state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         PREAMBLE_LEN  = 7;
  localparam int         MIN_DATA      = 46;

  // Byte idx (0 = most significant) of a 48-bit MAC address.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [47:0] sh;
    sh = mac << {idx, 3'b000};
    return sh[47:40];
  endfunction

endpackage

// File: rtl/eth_frame_builder_sync_fifo.sv
// Single-clock FIFO with registered read port; pop_data updates the cycle after a pop
// and holds until the next pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full     = (r_count == (AW+1)'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign pop_data = r_rd_data;
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
    end
  end

  // Storage kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
    if (w_pop)  r_rd_data <= r_mem[r_rd_ptr];
  end

endmodule

// File: rtl/eth_frame_builder.sv
// Chunks an upstream byte stream into byte-paced Ethernet frames (FCS added downstream).
// Define ETH_SEQ_NUM_EN to insert a 16-bit frame sequence number ahead of the payload.
module eth_frame_builder
  import eth_pkg::*;
#(
  parameter int          MAX_PAYLOAD = 1024,
  parameter int          DATA_DEPTH  = 2048,
  parameter int          LEN_DEPTH   = 4,
  parameter int          BYTE_CYCLES = 4,
  parameter int          IFG_BYTES   = 16,
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_byte,
  output logic       out_valid,
  output logic       out_crc_en,
  output logic       out_last,
  output logic       busy
);

  localparam int TW = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;
  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int LAW = $clog2(LEN_DEPTH);

  logic [10:0]  r_chunk_cnt;
  logic [10:0]  w_chunk_len;
  logic         w_accept;
  logic         w_commit;
  logic [7:0]   w_data_rd;
  logic         w_data_full;
  logic         w_data_empty;
  logic [DAW:0] w_data_count;
  logic         w_data_pop;
  logic [10:0]  w_plen;
  logic         w_len_full;
  logic         w_len_empty;
  logic [LAW:0] w_len_count;
  logic         w_len_pop;

  state_t       r_state;
  state_t       w_state_next;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_next;
  logic [10:0]  r_cnt;
  logic [10:0]  w_cnt_next;
  logic [10:0]  r_data_cnt;
  logic [10:0]  w_data_cnt_next;
  logic [10:0]  w_data_cnt_inc;
  logic         w_byte_end;
  logic         w_frame_done;
  logic         w_strobe;
  logic         w_last_byte;
  logic [7:0]   w_byte;
  logic [7:0]   w_seq_byte;
  logic         w_unused;

  // ---------------- input side ----------------
  assign in_ready    = !rst && !w_data_full && !w_len_full;
  assign w_accept    = in_valid && in_ready;
  assign w_chunk_len = r_chunk_cnt + 11'd1;
  assign w_commit    = w_accept && (in_last || (w_chunk_len == 11'(MAX_PAYLOAD)));

  always_ff @(posedge clk) begin
    if (rst)           r_chunk_cnt <= '0;
    else if (w_commit) r_chunk_cnt <= '0;
    else if (w_accept) r_chunk_cnt <= w_chunk_len;
  end

  sync_fifo #(.WIDTH(8), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_accept),
    .push_data (in_data),
    .pop       (w_data_pop),
    .pop_data  (w_data_rd),
    .full      (w_data_full),
    .empty     (w_data_empty),
    .count     (w_data_count)
  );

  // Popped length stays on pop_data for the whole frame, so it serves as plen.
  sync_fifo #(.WIDTH(11), .DEPTH(LEN_DEPTH)) u_len_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_commit),
    .push_data (w_chunk_len),
    .pop       (w_len_pop),
    .pop_data  (w_plen),
    .full      (w_len_full),
    .empty     (w_len_empty),
    .count     (w_len_count)
  );

  // ---------------- frame FSM ----------------
  assign w_byte_end     = (r_timer == TW'(BYTE_CYCLES - 1));
  assign w_data_cnt_inc = r_data_cnt + 11'd1;

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_timer_next    = '0;
    w_data_cnt_next = r_data_cnt;
    w_len_pop       = 1'b0;
    w_frame_done    = 1'b0;
    if (r_state == IDLE) begin
      w_cnt_next      = '0;
      w_data_cnt_next = '0;
      if (!w_len_empty) begin
        w_len_pop    = 1'b1;
        w_state_next = PREAMBLE;
      end
    end else if (!w_byte_end) begin
      w_timer_next = r_timer + TW'(1);
    end else begin
      w_cnt_next = r_cnt + 11'd1;
      case (r_state)
        PREAMBLE: if (r_cnt == 11'(PREAMBLE_LEN - 1)) w_state_next = SFD;
        SFD:      w_state_next = DST;
        DST:      if (r_cnt == 11'd5) w_state_next = SRC;
        SRC:      if (r_cnt == 11'd5) w_state_next = TYPE;
        TYPE: begin
          if (r_cnt == 11'd1) begin
`ifdef ETH_SEQ_NUM_EN
            w_state_next = SEQ;
`else
            w_state_next = PAYLOAD;
`endif
          end
        end
        SEQ: begin
          w_data_cnt_next = w_data_cnt_inc;
          if (r_cnt == 11'd1) w_state_next = PAYLOAD;
        end
        PAYLOAD: begin
          w_data_cnt_next = w_data_cnt_inc;
          if (r_cnt == w_plen - 11'd1) begin
            if (w_data_cnt_inc < 11'(MIN_DATA)) begin
              w_state_next = PAD;
            end else begin
              w_state_next = IFG;
              w_frame_done = 1'b1;
            end
          end
        end
        PAD: begin
          w_data_cnt_next = w_data_cnt_inc;
          if (w_data_cnt_inc >= 11'(MIN_DATA)) begin
            w_state_next = IFG;
            w_frame_done = 1'b1;
          end
        end
        IFG:      if (r_cnt == 11'(IFG_BYTES - 1)) w_state_next = IDLE;
        default:  w_state_next = IDLE;
      endcase
      if (w_state_next != r_state) w_cnt_next = '0;
    end
  end

  // Fetch one cycle ahead so the registered FIFO read lands on the strobe cycle.
  assign w_data_pop = (r_state != IDLE) && w_byte_end && (w_state_next == PAYLOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_cnt      <= '0;
      r_data_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_timer    <= w_timer_next;
      r_cnt      <= w_cnt_next;
      r_data_cnt <= w_data_cnt_next;
    end
  end

`ifdef ETH_SEQ_NUM_EN
  logic [15:0] r_seq;
  always_ff @(posedge clk) begin
    if (rst)               r_seq <= '0;
    else if (w_frame_done) r_seq <= r_seq + 16'd1;
  end
  assign w_seq_byte = (r_cnt == 11'd0) ? r_seq[15:8] : r_seq[7:0];
`else
  assign w_seq_byte = 8'h00;
`endif

  // ---------------- outputs ----------------
  assign w_strobe    = (r_state inside {PREAMBLE, SFD, DST, SRC, TYPE, SEQ, PAYLOAD, PAD})
                       && (r_timer == '0);
  assign w_last_byte = ((r_state == PAYLOAD) && (r_cnt == w_plen - 11'd1)
                        && (w_data_cnt_inc >= 11'(MIN_DATA)))
                       || ((r_state == PAD) && (w_data_cnt_inc >= 11'(MIN_DATA)));

  always_comb begin
    w_byte = 8'h00;
    case (r_state)
      PREAMBLE: w_byte = PREAMBLE_BYTE;
      SFD:      w_byte = SFD_BYTE;
      DST:      w_byte = mac_byte(DST_MAC, r_cnt[2:0]);
      SRC:      w_byte = mac_byte(SRC_MAC, r_cnt[2:0]);
      TYPE:     w_byte = r_cnt[0] ? ETHERTYPE[7:0] : ETHERTYPE[15:8];
      SEQ:      w_byte = w_seq_byte;
      PAYLOAD:  w_byte = w_data_rd;
      default:  w_byte = 8'h00;
    endcase
  end

  assign out_byte   = rst ? 8'h00 : w_byte;
  assign out_valid  = !rst && w_strobe;
  assign out_crc_en = !rst && w_strobe && (r_state inside {DST, SRC, TYPE, SEQ, PAYLOAD, PAD});
  assign out_last   = !rst && w_strobe && w_last_byte;
  assign busy       = !rst && (r_state != IDLE);

  assign w_unused = ^{w_data_count, w_len_count, w_data_empty, w_frame_done};

endmodule

// File: tb/tb_eth_frame_builder.sv
// Self-checking bench: frame-level reference model fed from accepted input bytes,
// checked on every output strobe, plus literal checks of frame layout and timing.
module tb_eth_frame_builder;

  localparam int MAXP  = 1024;
  localparam int BC    = 4;
  localparam int IFGB  = 16;
  localparam int FGAP  = 1 + (IFGB + 1) * BC;
`ifdef ETH_SEQ_NUM_EN
  localparam int SEQB = 2;
`else
  localparam int SEQB = 0;
`endif
  localparam int HDR = 22 + SEQB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [7:0] out_byte;
  logic       out_valid, out_crc_en, out_last, busy;

  always #5 clk = ~clk;

  eth_frame_builder #(
    .MAX_PAYLOAD (MAXP), .DATA_DEPTH (2048), .LEN_DEPTH (4), .BYTE_CYCLES (BC),
    .IFG_BYTES (IFGB), .DST_MAC (48'hFFFF_FFFF_FFFF), .SRC_MAC (48'h02_00_00_00_00_01),
    .ETHERTYPE (16'h88B5)
  ) dut (
    .clk (clk), .rst (rst), .in_data (in_data), .in_valid (in_valid), .in_last (in_last),
    .in_ready (in_ready), .out_byte (out_byte), .out_valid (out_valid),
    .out_crc_en (out_crc_en), .out_last (out_last), .busy (busy)
  );

  typedef struct packed { logic [7:0] b; logic crc; logic last; } exp_t;
  exp_t       exp_q[$];
  logic [7:0] chunk_q[$];
  int         seq_num = 0;
  int         n_vec = 0, n_err = 0;
  int         cyc = 0;
  logic [7:0] log_b   [0:4095];
  logic       log_crc [0:4095];
  logic       log_last[0:4095];
  int         log_n = 0;
  int         gap_log[0:63];
  int         gap_n = 0;
  int         frames_seen = 0;
  int         last_strobe_cyc = 0;
  bit         have_prev = 0, prev_last = 0, stall_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: turn the completed chunk into the full list of strobes it must produce.
  task automatic build_frame();
    logic [47:0] dst, src;
    logic [7:0]  hdr[$];
    logic [7:0]  dq[$];
    dst = 48'hFFFF_FFFF_FFFF;
    src = 48'h02_00_00_00_00_01;
    for (int i = 0; i < 7; i++) hdr.push_back(8'h55);
    hdr.push_back(8'hD5);
    for (int i = 0; i < 6; i++) hdr.push_back(dst[47 - 8*i -: 8]);
    for (int i = 0; i < 6; i++) hdr.push_back(src[47 - 8*i -: 8]);
    hdr.push_back(8'h88);
    hdr.push_back(8'hB5);
`ifdef ETH_SEQ_NUM_EN
    dq.push_back(8'((seq_num >> 8) & 255));
    dq.push_back(8'(seq_num & 255));
    seq_num = (seq_num + 1) & 16'hFFFF;
`endif
    foreach (chunk_q[i]) dq.push_back(chunk_q[i]);
    while (dq.size() < 46) dq.push_back(8'h00);
    foreach (hdr[i]) exp_q.push_back('{b: hdr[i], crc: (i >= 8), last: 1'b0});
    foreach (dq[i]) exp_q.push_back('{b: dq[i], crc: 1'b1, last: (i == dq.size() - 1)});
    chunk_q.delete();
  endtask

  task automatic model_accept(input logic [7:0] d, input logic l);
    chunk_q.push_back(d);
    if (l || chunk_q.size() == MAXP) build_frame();
  endtask

  task automatic model_reset();
    exp_q.delete();
    chunk_q.delete();
    seq_num = 0;
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] d, input logic l);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int k = 0; k < 20000; k++) begin
      #1;
      if (in_ready) begin
        model_accept(d, l);
        ok = 1;
        @(negedge clk);
        break;
      end
      stall_seen = 1;
      @(negedge clk);
    end
    if (!ok) chk("in_ready_timeout", 0, 1);
  endtask

  task automatic send_unit(input int len, input bit rnd, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
      end
      send_byte(rnd ? 8'($urandom) : 8'(i + 1), i == len - 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 30000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    chk("drain_pending", exp_q.size(), 0);
    chk("drain_timeout", (k < 30000) ? 1 : 0, 1);
  endtask

  // Compare process: every strobe is checked against the model and its timing.
  always @(negedge clk) begin
    int   g;
    exp_t e;
    if (rst) begin
      have_prev = 0;
    end else begin
      chk("flags_without_valid", (!out_valid && (out_crc_en || out_last)) ? 1 : 0, 0);
      if (out_valid) begin
        if (have_prev) begin
          g = cyc - last_strobe_cyc;
          if (prev_last) begin
            if (gap_n < 64) gap_log[gap_n] = g;
            gap_n++;
            chk("frame_gap_min", (g >= FGAP) ? 1 : 0, 1);
          end else begin
            chk("byte_spacing", g, BC);
          end
        end
        chk("strobe_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_byte", out_byte, e.b);
          chk("out_crc_en", out_crc_en, e.crc);
          chk("out_last", out_last, e.last);
        end
        if (log_n < 4096) begin
          log_b[log_n]    = out_byte;
          log_crc[log_n]  = out_crc_en;
          log_last[log_n] = out_last;
        end
        log_n++;
        if (out_last) frames_seen++;
        have_prev       = 1;
        prev_last       = out_last;
        last_strobe_cyc = cyc;
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, k, tgt;
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_byte", out_byte, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);

    // 10-byte unit 0x01..0x0A, literal layout and IFG length.
    log_n = 0;
    send_unit(10, 0, 0);
    for (k = 0; k < 2000 && exp_q.size() != 0; k++) @(negedge clk);
    for (k = 0; k < 200 && busy; k++) @(negedge clk);
    chk("t1_idle_after_last", cyc - last_strobe_cyc, 68);
    chk("t1_strobes", log_n, 68);
    chk("t1_pre0", log_b[0], 8'h55);
    chk("t1_sfd", log_b[7], 8'hD5);
    chk("t1_sfd_crc", log_crc[7], 0);
    chk("t1_dst0", log_b[8], 8'hFF);
    chk("t1_dst0_crc", log_crc[8], 1);
    chk("t1_src0", log_b[14], 8'h02);
    chk("t1_src5", log_b[19], 8'h01);
    chk("t1_type0", log_b[20], 8'h88);
    chk("t1_type1", log_b[21], 8'hB5);
    chk("t1_pay0", log_b[HDR], 8'h01);
    chk("t1_pay9", log_b[HDR + 9], 8'h0A);
    chk("t1_final", log_b[67], 8'h00);
    chk("t1_final_last", log_last[67], 1);
    chk("t1_prev_not_last", log_last[66], 0);

    // Randomized units with random idle cycles.
    for (int u = 0; u < 6; u++) send_unit($urandom_range(1, 120), 1, 1);
    drain();

    // 2500-byte stream, one in_last: 1024/1024/452, back-to-back frames, data FIFO stalls.
    @(negedge clk);
    f0 = frames_seen;
    gap_n = 0;
    stall_seen = 0;
    send_unit(2500, 1, 0);
    chk("t2_data_fifo_stall", stall_seen, 1);
    drain();
    chk("t2_frames", frames_seen - f0, 3);
    chk("t2_gap_count", gap_n, 3);
    chk("t2_gap_a", gap_log[1], FGAP);
    chk("t2_gap_b", gap_log[2], FGAP);

    // Many tiny units: length FIFO fills and stalls upstream.
    @(negedge clk);
    stall_seen = 0;
    for (int u = 0; u < 12; u++) send_unit(2, 1, 0);
    chk("t3_len_fifo_stall", stall_seen, 1);
    drain();

    // Exactly 46 bytes: no pad.
    @(negedge clk);
    f0 = frames_seen;
    log_n = 0;
    send_unit(46, 1, 0);
    drain();
    chk("t4_frames", frames_seen - f0, 1);
    chk("t4_strobes", log_n, HDR + 46);

    // Exactly MAX_PAYLOAD bytes with in_last on the final byte: single frame.
    @(negedge clk);
    f0 = frames_seen;
    log_n = 0;
    send_unit(MAXP, 1, 0);
    drain();
    chk("t5_frames", frames_seen - f0, 1);
    chk("t5_strobes", log_n, HDR + MAXP);

    // Reset during payload byte 5, then a fresh 46-byte unit.
    @(negedge clk);
    log_n = 0;
    tgt = HDR + 5;
    send_unit(60, 1, 0);
    for (k = 0; k < 2000 && log_n < tgt; k++) @(negedge clk);
    chk("t6_reached_payload5", (log_n == tgt) ? 1 : 0, 1);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_post_in_ready", in_ready, 1);
    chk("t6_post_busy", busy, 0);
    f0 = frames_seen;
    log_n = 0;
    send_unit(46, 1, 0);
    drain();
    chk("t6_frames", frames_seen - f0, 1);
    chk("t6_strobes", log_n, HDR + 46);

`ifdef ETH_SEQ_NUM_EN
    // Sequence numbers restart at zero after reset and increment per frame.
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    log_n = 0;
    for (int u = 0; u < 3; u++) send_unit(50, 1, 0);
    drain();
    chk("t7_strobes", log_n, 3 * 74);
    chk("t7_seq0_hi", log_b[22], 8'h00);
    chk("t7_seq0_lo", log_b[23], 8'h00);
    chk("t7_seq1_lo", log_b[74 + 23], 8'h01);
    chk("t7_seq2_hi", log_b[148 + 22], 8'h00);
    chk("t7_seq2_lo", log_b[148 + 23], 8'h02);
    chk("t7_type_before_seq", log_b[148 + 21], 8'hB5);
`endif

    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
